// File: rtl/hit_judge.sv
// hit_judge: rhythm-game judge. Each step pulse closes the current judge
// window, compares the lanes pressed during it against the target row that
// was latched when the window opened, and opens the next window.
//
// Protocol: step is a single-cycle strobe with no back-pressure. The window
// it closes is judged at that edge. hit or miss is a registered single-cycle
// strobe that appears in the cycle after step. Only one of them is high, and
// neither is high when nothing was due and nothing was pressed. There is no
// ready signal, so every step is consumed on the edge where it is sampled.
module hit_judge #(
  parameter int POINTS = 10,
  parameter int SW     = 16
) (
  input  logic          C,
  input  logic          INIT,
  input  logic [3:0]    row,
  input  logic          step,
  input  logic [3:0]    btn,
  input  logic          en,
  output logic          hit,
  output logic          miss,
  output logic [SW-1:0] score,
  output logic [7:0]    combo,
  output logic [7:0]    max_combo,
  output logic [3:0]    pressed,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } state_t;

  localparam logic [SW:0] PTS = (SW+1)'(POINTS);

  state_t        cur;
  logic [3:0]    btn_q;
  logic [3:0]    target;
  logic [3:0]    edges;
  logic          judge_hit;
  logic          judge_miss;
  logic [SW:0]   score_sum;
  logic [SW-1:0] score_inc;
  logic [7:0]    combo_inc;

  // Debug view of the FSM for checkers and LEDs.
  assign state = cur;

  // Press edges, and the verdict and counter updates for the closing window.
  // The verdict is "miss" whenever the pressed set differs from the target.
  // That single test covers a missing lane, an extra lane and a false press
  // on an empty row.
  always_comb begin
    edges      = btn & ~btn_q;
    judge_hit  = (target != 4'd0) && (pressed == target);
    judge_miss = (pressed != target);
    score_sum  = {1'b0, score} + PTS;
    score_inc  = score_sum[SW] ? {SW{1'b1}} : score_sum[SW-1:0];
    combo_inc  = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;
  end

  // FSM, window bookkeeping, verdict strobes and score/combo counters.
  always_ff @(posedge C) begin
    if (INIT) begin
      cur       <= IDLE;
      hit       <= 1'b0;
      miss      <= 1'b0;
      score     <= '0;
      combo     <= 8'd0;
      max_combo <= 8'd0;
      pressed   <= 4'd0;
      target    <= 4'd0;
      btn_q     <= 4'd0;
    end else begin
      btn_q <= btn;
      hit   <= 1'b0;
      miss  <= 1'b0;
      if (!en) begin
        // The open window is dropped without a verdict. The counters hold.
        cur     <= IDLE;
        pressed <= 4'd0;
      end else begin
        case (cur)
          IDLE: begin
            // A step arriving together with en is deliberately not consumed.
            cur <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (step) begin
              target  <= row;
              pressed <= edges;
              cur     <= RUN;
            end
          end
          RUN: begin
            if (step) begin
              hit     <= judge_hit;
              miss    <= judge_miss;
              target  <= row;
              pressed <= edges;
              if (judge_hit) begin
                score <= score_inc;
                combo <= combo_inc;
                if (combo_inc > max_combo) max_combo <= combo_inc;
              end else if (judge_miss) begin
                combo <= 8'd0;
              end
            end else begin
              pressed <= pressed | edges;
            end
          end
          default: cur <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Testbench for hit_judge: directed scenarios plus a randomized window run.
// Expected verdicts are queued when a step is driven and popped when the
// verdict strobe is due.
module tb_hit_judge;

  localparam logic [1:0] R_NONE = 2'b00;
  localparam logic [1:0] R_HIT  = 2'b10;
  localparam logic [1:0] R_MISS = 2'b01;

  logic        C = 1'b0;
  logic        INIT;
  logic [3:0]  row;
  logic        step;
  logic [3:0]  btn;
  logic        en;
  logic        hit;
  logic        miss;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [3:0]  pressed;
  logic [1:0]  state;

  logic [1:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_score, m_combo, m_max;
  logic [3:0]  cur_target;

  hit_judge #(.POINTS(10), .SW(16)) dut (
    .C(C), .INIT(INIT), .row(row), .step(step), .btn(btn), .en(en),
    .hit(hit), .miss(miss), .score(score), .combo(combo),
    .max_combo(max_combo), .pressed(pressed), .state(state)
  );

  // Clock and reset.
  always #5 C = ~C;

  task automatic cycle();
    @(posedge C);
    @(negedge C);
  endtask

  task automatic model_reset();
    m_score    = 0;
    m_combo    = 0;
    m_max      = 0;
    cur_target = 4'd0;
  endtask

  // Driver tasks.
  task automatic press(input logic [3:0] m);
    btn = btn | m;
    cycle();
    btn = btn & ~m;
    cycle();
  endtask

  // Closes the current window with row r as the next target. The verdict
  // is checked against the scoreboard, and the counters against the model.
  task automatic do_step(input logic [3:0] r, input logic [1:0] e);
    logic [1:0] got, want;
    row  = r;
    step = 1'b1;
    exp_q.push_back(e);
    cycle();
    step = 1'b0;
    got  = {hit, miss};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL step_result: got hit/miss=%b expected %b", got, want);
    end
    if (want == R_HIT) begin
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      m_combo = (m_combo == 255) ? 255 : m_combo + 1;
      if (m_combo > m_max) m_max = m_combo;
    end else if (want == R_MISS) begin
      m_combo = 0;
    end
    n_checks++;
    if (score !== m_score[15:0]) begin
      n_fail++;
      $display("FAIL step_score: got %0d expected %0d", score, m_score);
    end
    n_checks++;
    if (combo !== m_combo[7:0]) begin
      n_fail++;
      $display("FAIL step_combo: got %0d expected %0d", combo, m_combo);
    end
    n_checks++;
    if (max_combo !== m_max[7:0]) begin
      n_fail++;
      $display("FAIL step_max_combo: got %0d expected %0d", max_combo, m_max);
    end
    cycle();
    n_checks++;
    if ({hit, miss} !== 2'b00) begin
      n_fail++;
      $display("FAIL pulse_width: got hit/miss=%b expected 00", {hit, miss});
    end
    cur_target = r;
  endtask

  task automatic restart();
    INIT = 1'b1;
    cycle();
    INIT = 1'b0;
    model_reset();
    cycle();
    do_step(4'b0001, R_NONE);
  endtask

  // Scenario tasks.
  task automatic test_reset();
    INIT = 1'b1; en = 1'b0; step = 1'b0; btn = 4'd0; row = 4'd0;
    cycle();
    cycle();
    INIT = 1'b0;
    model_reset();
    n_checks++;
    if ({hit, miss, score, combo, max_combo, pressed, state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hit=%b miss=%b score=%0d combo=%0d max=%0d pressed=%b state=%0d expected all 0",
               hit, miss, score, combo, max_combo, pressed, state);
    end
  endtask

  task automatic test_single_hit();
    en = 1'b1;
    cycle();
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL wait_first_state: got %0d expected 1", state);
    end
    press(4'b0001);
    n_checks++;
    if (pressed !== 4'd0) begin
      n_fail++;
      $display("FAIL wait_first_ignores_press: got %b expected 0000", pressed);
    end
    do_step(4'b0001, R_NONE);
    n_checks++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL run_state: got %0d expected 2", state);
    end
    press(4'b0001);
    n_checks++;
    if (pressed !== 4'b0001) begin
      n_fail++;
      $display("FAIL pressed_lane0: got %b expected 0001", pressed);
    end
    do_step(4'b0110, R_HIT);
    n_checks++;
    if (score !== 16'd10 || combo !== 8'd1 || max_combo !== 8'd1) begin
      n_fail++;
      $display("FAIL first_hit_counters: got %0d/%0d/%0d expected 10/1/1", score, combo, max_combo);
    end
  endtask

  task automatic test_miss();
    press(4'b0010);
    do_step(4'b0000, R_MISS);
    n_checks++;
    if (combo !== 8'd0 || score !== 16'd10) begin
      n_fail++;
      $display("FAIL partial_miss: got combo=%0d score=%0d expected 0/10", combo, score);
    end
  endtask

  task automatic test_false_press();
    press(4'b1000);
    do_step(4'b0000, R_MISS);
    do_step(4'b0001, R_NONE);
  endtask

  task automatic test_en_drop();
    press(4'b0001);
    en = 1'b0;
    cycle();
    n_checks++;
    if ({hit, miss} !== 2'b00 || pressed !== 4'd0 || state !== 2'd0 || score !== 16'd10) begin
      n_fail++;
      $display("FAIL en_drop: got hm=%b pressed=%b state=%0d score=%0d expected 00/0000/0/10",
               {hit, miss}, pressed, state, score);
    end
    en = 1'b1;
    cycle();
    do_step(4'b0001, R_NONE);
  endtask

  task automatic test_combo();
    restart();
    for (int i = 0; i < 5; i++) begin
      press(4'b0001);
      do_step(4'b0001, R_HIT);
    end
    do_step(4'b0001, R_MISS);
    press(4'b0001);
    do_step(4'b0001, R_HIT);
    press(4'b0001);
    do_step(4'b0100, R_HIT);
    n_checks++;
    if (combo !== 8'd2 || max_combo !== 8'd5 || score !== 16'd70) begin
      n_fail++;
      $display("FAIL combo_run: got %0d/%0d/%0d expected combo 2 max 5 score 70", combo, max_combo, score);
    end
  endtask

  task automatic test_held();
    btn = 4'b0100;
    cycle();
    do_step(4'b0100, R_HIT);
    do_step(4'b0000, R_MISS);
    btn = 4'd0;
    cycle();
  endtask

  task automatic test_init_mid();
    press(4'b0001);
    INIT = 1'b1;
    step = 1'b1;
    cycle();
    INIT = 1'b0;
    step = 1'b0;
    model_reset();
    n_checks++;
    if ({hit, miss, score, combo, max_combo, pressed, state} !== '0) begin
      n_fail++;
      $display("FAIL init_mid_window: got hm=%b score=%0d combo=%0d max=%0d pressed=%b state=%0d expected all 0",
               {hit, miss}, score, combo, max_combo, pressed, state);
    end
    cycle();
    do_step(4'b0010, R_NONE);
    btn = 4'b0010;
    do_step(4'b0010, R_MISS);
    n_checks++;
    if (pressed !== 4'b0010) begin
      n_fail++;
      $display("FAIL edge_at_step: got pressed=%b expected 0010", pressed);
    end
    btn = 4'd0;
    do_step(4'b0000, R_HIT);
  endtask

  task automatic test_combo_sat();
    restart();
    for (int i = 0; i < 256; i++) begin
      press(4'b0001);
      do_step(4'b0001, R_HIT);
    end
    n_checks++;
    if (combo !== 8'd255 || max_combo !== 8'd255 || score !== 16'd2560) begin
      n_fail++;
      $display("FAIL combo_saturation: got %0d/%0d/%0d expected 255/255/2560", combo, max_combo, score);
    end
  endtask

  task automatic test_random();
    logic [3:0] m, nr;
    logic [1:0] e;
    for (int i = 0; i < 40; i++) begin
      m  = $urandom_range(0, 1) ? cur_target : 4'($urandom_range(0, 15));
      nr = 4'($urandom_range(0, 15));
      if (cur_target != 4'd0 && m == cur_target) e = R_HIT;
      else if (m != cur_target)                 e = R_MISS;
      else                                      e = R_NONE;
      if (m != 4'd0) press(m);
      do_step(nr, e);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss();
    test_false_press();
    test_en_drop();
    test_combo();
    test_held();
    test_init_mid();
    test_combo_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
